accel_mem_req: RTL

ACCEL_MEM_REQ -- requirements
Module: accel_mem_req

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/accel_req_fifo.sv | 75 +++++++
 rtl/accel_mem_req.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accelerator memory-request path.
// Contents:
//   ADDR_W / WORD_W / LINE_W : address, write-word and read-line widths
//   state_e                  : request FSM states
//   req_entry_t              : one queued request {wr, addr, wdata}
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;
  localparam int LINE_W = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/accel_req_fifo.sv
// Request queue for accel_mem_req: DEPTH-entry FIFO of req_entry_t with
// wrapping pointers and an occupancy count 0..DEPTH.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push           : enqueue request (accepted only when push_ready)
//   push_entry     : entry to enqueue
//   push_ready     : count != DEPTH, from the registered count
//   pop            : dequeue head (ignored when empty)
//   head           : entry at the read pointer
//   count          : registered occupancy
module accel_req_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  req_entry_t       push_entry,
  output logic             push_ready,
  input  logic             pop,
  output req_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  req_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_fire;
  logic             pop_fire;

  // Readiness comes only from the registered count, so a push while full is
  // refused even if the head is popped in the same cycle.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign push_fire  = push && push_ready;
  assign pop_fire   = pop && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/accel_mem_req.sv
// Accelerator memory-request front end. Queues accelerator requests and
// issues them in strict order to the datamem arbiter accel slot; reads return
// a 512-bit line through a response register held until accepted.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; valid never depends combinationally on ready. req_* transfers into
// the queue; rsp_* transfers a read line out. mem_req/mem_gnt is a request /
// grant pair where a granted cycle (mem_req && mem_gnt) consumes the head.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_wr, req_addr, req_wdata     : request payload (wr=1 word write, 0 line read)
//   mem_req, mem_gnt                : arbiter request / grant
//   mem_addr, mem_wrt_data, mem_wrt_en : arbiter accel port
//   mem_rd_data                     : line valid one cycle after a granted read
//   rsp_valid/rsp_ready             : response handshake
//   rsp_data, rsp_addr              : returned line and its address
//   busy                            : queue non-empty or FSM not idle
//   dbg_state                       : current FSM state
module accel_mem_req
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wrt_data,
  output logic              mem_wrt_en,
  input  logic [LINE_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  req_entry_t        push_entry;
  req_entry_t        head;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push_fire;

  assign push_entry = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  assign push_fire  = req_valid && req_ready;

  accel_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (req_valid),
    .push_entry (push_entry),
    .push_ready (req_ready),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    pop          = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_wrt_data = '0;
    mem_wrt_en   = 1'b0;
    rsp_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Without a grant the CPU owns the port; everything holds.
        mem_req      = 1'b1;
        mem_addr     = head.addr;
        mem_wrt_data = head.wdata;
        if (mem_gnt) begin
          pop = 1'b1;
          if (head.wr) begin
            mem_wrt_en = 1'b1;
            // Stay in ISSUE if anything remains after this pop, counting a
            // request that enters the queue on the same edge.
            state_d = ((count != CNT_W'(1)) || push_fire) ? ST_ISSUE : ST_IDLE;
          end else begin
            rsp_addr_d = head.addr;
            state_d    = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rsp_data_d = mem_rd_data;
        state_d    = ST_RSP;
      end
      ST_RSP: begin
        // The queue head is not issued until the line is accepted, keeping
        // later writes behind the read.
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = (count != '0) ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign busy      = (count != '0) || (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
